alu_seq_ctrl: RTL

Issue controller that sequences the 20-bit ALU. It accepts one instruction at a time from the decoder over a valid/ready handshake and fetches both operands from the register file. It then executes the instruction, driving the ALU for logic, shift and INC/DEC ops and computing carry arithmetic and compares internally, and writes the result back. It also owns the architectural flags (C, Z, T), since the ALU itself is combinational and stateless.

---
 rtl/alu_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue controller sequencing a 20-bit combinational ALU.
// Accepts one instruction at a time, reads both operands from the register
// file, executes (ALU ops externally, carry arithmetic and compares
// internally), writes back and owns the C/Z/T flags.
// Optional build macro: ALU_SEQ_ILLEGAL_TRAP_EN -- an illegal opcode latches
// err_illegal and parks the FSM in TRAP until reset. Without it an illegal
// opcode is a NOP that pulses err_illegal for its EXEC cycle.
// Handshake: an instruction is taken on a rising edge where issue_valid and
// issue_ready are both high; issue_ready is high only in IDLE and issue_*
// are ignored at every other time.
module alu_seq_ctrl #(
    parameter int DATA_W = 20,
    parameter int RF_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] issue_op,
    input  logic [RF_AW-1:0]  issue_rd,
    input  logic [RF_AW-1:0]  issue_rs,
    output logic [RF_AW-1:0]  rf_raddr_a,
    output logic [RF_AW-1:0]  rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_t,
    output logic              busy,
    output logic              err_illegal,
    output logic [2:0]        dbg_state
);

    localparam logic [DATA_W-1:0] OP_NOT   = 20'h000A1;
    localparam logic [DATA_W-1:0] OP_OR    = 20'h000C9;
    localparam logic [DATA_W-1:0] OP_AND   = 20'h000B5;
    localparam logic [DATA_W-1:0] OP_XOR   = 20'h000DD;
    localparam logic [DATA_W-1:0] OP_SHFTR = 20'h000F1;
    localparam logic [DATA_W-1:0] OP_SHFTL = 20'h00105;
    localparam logic [DATA_W-1:0] OP_ROTR  = 20'h00119;
    localparam logic [DATA_W-1:0] OP_ROTL  = 20'h0012D;
    localparam logic [DATA_W-1:0] OP_SWAP  = 20'h00011;
    localparam logic [DATA_W-1:0] OP_INC   = 20'h00141;
    localparam logic [DATA_W-1:0] OP_DEC   = 20'h00155;
    localparam logic [DATA_W-1:0] OP_ADD   = 20'h00169;
    localparam logic [DATA_W-1:0] OP_ADDC  = 20'h0017D;
    localparam logic [DATA_W-1:0] OP_SUB   = 20'h00191;
    localparam logic [DATA_W-1:0] OP_SUBC  = 20'h001A5;
    localparam logic [DATA_W-1:0] OP_EQ    = 20'h001B9;
    localparam logic [DATA_W-1:0] OP_GT    = 20'h001CD;
    localparam logic [DATA_W-1:0] OP_LT    = 20'h001E1;
    localparam logic [DATA_W-1:0] OP_GET   = 20'h001F5;
    localparam logic [DATA_W-1:0] OP_LET   = 20'h00209;

    // Rotate amounts wrap at the datapath width; shifts at or past it clear.
    localparam logic [DATA_W-1:0] ROT_MOD  = 20'd20;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_WB2  = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   op_q;
    logic [RF_AW-1:0]    rd_q, rs_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                c_q, c_d, z_q, z_d, t_q, t_d;
    logic [DATA_W:0]     sum;
    logic                is_alu, is_shift, is_rot, is_arith, is_cmp, is_swap, is_ill;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic                err_q;
`endif

    // Classify the latched opcode.
    always_comb begin
        is_alu   = 1'b0;
        is_shift = 1'b0;
        is_rot   = 1'b0;
        is_arith = 1'b0;
        is_cmp   = 1'b0;
        is_swap  = 1'b0;
        is_ill   = 1'b0;
        case (op_q)
            OP_NOT, OP_OR, OP_AND, OP_XOR, OP_INC, OP_DEC: is_alu = 1'b1;
            OP_SHFTR, OP_SHFTL: begin
                is_alu   = 1'b1;
                is_shift = 1'b1;
            end
            OP_ROTR, OP_ROTL: begin
                is_alu = 1'b1;
                is_rot = 1'b1;
            end
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: is_arith = 1'b1;
            OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET: is_cmp = 1'b1;
            OP_SWAP: is_swap = 1'b1;
            default: is_ill = 1'b1;
        endcase
    end

    // EXEC-cycle datapath: operands come straight from the RF read port.
    always_comb begin
        res_d = '0;
        c_d   = c_q;
        t_d   = t_q;
        sum   = '0;
        case (op_q)
            OP_ADD:  sum = {1'b0, rf_rdata_a} + {1'b0, rf_rdata_b};
            OP_ADDC: sum = {1'b0, rf_rdata_a} + {1'b0, rf_rdata_b} + {{DATA_W{1'b0}}, c_q};
            OP_SUB:  sum = {1'b0, rf_rdata_a} - {1'b0, rf_rdata_b};
            OP_SUBC: sum = {1'b0, rf_rdata_a} - {1'b0, rf_rdata_b} - {{DATA_W{1'b0}}, c_q};
            default: sum = '0;
        endcase
        if (is_alu) begin
            res_d = (is_shift && (rf_rdata_b >= ROT_MOD)) ? '0 : alu_result;
        end
        if (is_arith) begin
            res_d = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
        end
        if (is_swap) begin
            res_d = rf_rdata_b;
        end
        case (op_q)
            OP_EQ:   t_d = (rf_rdata_a == rf_rdata_b);
            OP_GT:   t_d = (rf_rdata_a >  rf_rdata_b);
            OP_LT:   t_d = (rf_rdata_a <  rf_rdata_b);
            OP_GET:  t_d = (rf_rdata_a >= rf_rdata_b);
            OP_LET:  t_d = (rf_rdata_a <= rf_rdata_b);
            default: t_d = t_q;
        endcase
        z_d = (res_d == '0);
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d     = state_q;
        issue_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        err_illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) state_d = S_READ;
            end
            S_READ: begin
                rf_raddr_a = rd_q;
                rf_raddr_b = rs_q;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_op = op_q;
                    alu_a  = rf_rdata_a;
                    alu_b  = is_rot ? (rf_rdata_b % ROT_MOD) : rf_rdata_b;
                end
                if (is_cmp) begin
                    state_d = S_IDLE;
                end else if (is_ill) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    err_illegal = 1'b1;
                    state_d     = S_IDLE;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q;
                state_d  = is_swap ? S_WB2 : S_IDLE;
            end
            S_WB2: begin
                // Second SWAP write lands last, so rd == rs ends up holding A.
                rf_we    = 1'b1;
                rf_waddr = rs_q;
                rf_wdata = a_q;
                state_d  = S_IDLE;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        err_illegal = err_q;
`endif
    end

    // State, instruction latch, operand/result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            a_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            t_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && issue_valid) begin
                op_q <= issue_op;
                rd_q <= issue_rd;
                rs_q <= issue_rs;
            end
            if (state_q == S_EXEC) begin
                a_q <= rf_rdata_a;
                c_q <= c_d;
                t_q <= t_d;
                if (!is_cmp && !is_ill) begin
                    res_q <= res_d;
                    z_q   <= z_d;
                end
            end
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode indication, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_EXEC && is_ill) begin
            err_q <= 1'b1;
        end
    end
`endif

    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_t    = t_q;
    assign dbg_state = state_q;

endmodule
